// File: rtl/freelist_ctrl.sv
// Free list of physical register tags for a 2-wide rename stage.
// Circular FIFO with a speculative head (rename), an architectural head (commit) and a tail (frees).
module freelist_ctrl #(
    parameter  int PREG_NUM = 64,
    parameter  int LREG_NUM = 32,
    localparam int PREG_W   = $clog2(PREG_NUM),
    localparam int DEPTH    = PREG_NUM - LREG_NUM,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_fire,
    input  logic              instr0_alloc_req,
    input  logic              instr1_alloc_req,
    output logic [PREG_W-1:0] instr0_alloc_preg,
    output logic [PREG_W-1:0] instr1_alloc_preg,
    output logic              alloc_ready,
    input  logic              commit0_valid,
    input  logic [PREG_W-1:0] commit0_old_prd,
    input  logic              commit1_valid,
    input  logic [PREG_W-1:0] commit1_old_prd,
    input  logic              flush,
    output logic [PTR_W-1:0]  free_count,
    output logic              overflow_err
);

    localparam logic [PTR_W:0] DEPTH_X = DEPTH[PTR_W:0];

    logic [PREG_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  spec_head_q, spec_head_d;
    logic [PTR_W-1:0]  arch_head_q, arch_head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              overflow_q, overflow_d;

    logic [PTR_W-1:0]  count;
    logic [PTR_W-1:0]  n_free;
    logic [PTR_W-1:0]  n_alloc;
    logic [PTR_W:0]    count_after_free;
    logic              free_any;
    logic              free_drop;
    logic              alloc_ok;
    logic [IDX_W-1:0]  rd_idx0, rd_idx1;
    logic [IDX_W-1:0]  wr_idx0, wr_idx1;

    // Occupancy comes straight from the wrap-bit pointers; no separate counter to keep coherent.
    assign count            = tail_q - spec_head_q;
    assign n_free           = PTR_W'(commit0_valid) + PTR_W'(commit1_valid);
    assign n_alloc          = PTR_W'(instr0_alloc_req) + PTR_W'(instr1_alloc_req);
    assign count_after_free = {1'b0, count} + {1'b0, n_free};
    assign free_any         = commit0_valid | commit1_valid;
    assign free_drop        = free_any && (count_after_free > DEPTH_X);

    assign alloc_ready = (count >= PTR_W'(2));
    assign alloc_ok    = alloc_fire & alloc_ready & ~flush;
    assign free_count  = count;
    assign overflow_err = overflow_q;

    // DEPTH is a power of two, so index arithmetic wraps naturally in IDX_W bits.
    assign rd_idx0 = spec_head_q[IDX_W-1:0];
    assign rd_idx1 = rd_idx0 + IDX_W'(1);
    assign wr_idx0 = tail_q[IDX_W-1:0];
    assign wr_idx1 = wr_idx0 + IDX_W'(commit0_valid);

    // Responses depend only on registered state and the req bit, never on commit/flush.
    assign instr0_alloc_preg = fifo_q[rd_idx0];
    assign instr1_alloc_preg = instr0_alloc_req ? fifo_q[rd_idx1] : fifo_q[rd_idx0];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        spec_head_d = spec_head_q;
        arch_head_d = arch_head_q;
        tail_d      = tail_q;
        overflow_d  = overflow_q;

        if (free_drop) begin
            overflow_d = 1'b1;
        end else begin
            tail_d      = tail_q + n_free;
            arch_head_d = arch_head_q + n_free;
        end

        if (flush) begin
            spec_head_d = arch_head_d;
        end else if (alloc_ok) begin
            spec_head_d = spec_head_q + n_alloc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tag storage is reset on purpose: the initial contents are the free tags themselves.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= PREG_W'(LREG_NUM + i);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= {1'b1, {IDX_W{1'b0}}};
            overflow_q  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            overflow_q  <= overflow_d;
            if (!free_drop) begin
                if (commit0_valid) fifo_q[wr_idx0] <= commit0_old_prd;
                if (commit1_valid) fifo_q[wr_idx1] <= commit1_old_prd;
            end
        end
    end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Bench for freelist_ctrl: directed vectors feed a scoreboard queue drained by an independent monitor,
// followed by a random rename/commit/flush run that checks no tag is handed out while still owned.
module tb_freelist_ctrl;

    localparam int F_P0  = 0;
    localparam int F_P1  = 1;
    localparam int F_CNT = 2;
    localparam int F_RDY = 3;
    localparam int F_OVF = 4;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string name;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       alloc_fire;
    logic       instr0_alloc_req;
    logic       instr1_alloc_req;
    logic [5:0] instr0_alloc_preg;
    logic [5:0] instr1_alloc_preg;
    logic       alloc_ready;
    logic       commit0_valid;
    logic [5:0] commit0_old_prd;
    logic       commit1_valid;
    logic [5:0] commit1_old_prd;
    logic       flush;
    logic [5:0] free_count;
    logic       overflow_err;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q[$];

    freelist_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_fire        (alloc_fire),
        .instr0_alloc_req  (instr0_alloc_req),
        .instr1_alloc_req  (instr1_alloc_req),
        .instr0_alloc_preg (instr0_alloc_preg),
        .instr1_alloc_preg (instr1_alloc_preg),
        .alloc_ready       (alloc_ready),
        .commit0_valid     (commit0_valid),
        .commit0_old_prd   (commit0_old_prd),
        .commit1_valid     (commit1_valid),
        .commit1_old_prd   (commit1_old_prd),
        .flush             (flush),
        .free_count        (free_count),
        .overflow_err      (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input int fld, input int val, input string name);
        exp_t e;
        e.cyc = c; e.fld = fld; e.val = val; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic exp(input int fld, input int val, input string name);
        expect_at(cyc, fld, val, name);
    endtask

    task automatic drive(input logic fire, input logic r0, input logic r1,
                         input logic c0v, input logic [5:0] c0p,
                         input logic c1v, input logic [5:0] c1p, input logic fl);
        @(posedge clock);
        #1;
        alloc_fire       = fire;
        instr0_alloc_req = r0;
        instr1_alloc_req = r1;
        commit0_valid    = c0v;
        commit0_old_prd  = c0p;
        commit1_valid    = c1v;
        commit1_old_prd  = c1p;
        flush            = fl;
    endtask

    task automatic idle(input logic r0);
        drive(1'b0, r0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: independent of stimulus, compares whatever is due this cycle.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clock);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    check({e.name, "_stale"}, e.cyc, cyc);
                end else begin
                    case (e.fld)
                        F_P0:    act = int'(instr0_alloc_preg);
                        F_P1:    act = int'(instr1_alloc_preg);
                        F_CNT:   act = int'(free_count);
                        F_RDY:   act = int'(alloc_ready);
                        default: act = int'(overflow_err);
                    endcase
                    check(e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         owned[64];
        int         inflight[$];
        int         arch[$];
        int         freed[$];
        int         ncommit, mfree, j, t;
        logic       fire, r0, r1, fl, c0v, c1v;
        logic [5:0] c0p, c1p;

        reset = 1'b1;
        alloc_fire = 0; instr0_alloc_req = 0; instr1_alloc_req = 0;
        commit0_valid = 0; commit0_old_prd = 0; commit1_valid = 0; commit1_old_prd = 0; flush = 0;

        // Reset state
        do_reset();
        idle(1'b1);
        exp(F_P0, 32, "rst_p0"); exp(F_P1, 33, "rst_p1"); exp(F_CNT, 32, "rst_cnt");
        exp(F_RDY, 1, "rst_rdy"); exp(F_OVF, 0, "rst_ovf");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        exp(F_P1, 32, "rst_p1_noreq0");

        // Dual allocation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
            exp(F_P0, 32 + 2 * i, "dual_p0"); exp(F_P1, 33 + 2 * i, "dual_p1");
        end
        idle(1'b0);
        exp(F_CNT, 26, "dual_cnt"); exp(F_RDY, 1, "dual_rdy");

        // Only instr1 requests
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        exp(F_P1, 32, "i1only_p1");
        idle(1'b1);
        exp(F_P0, 33, "i1only_next_p0"); exp(F_CNT, 31, "i1only_cnt");

        // Drain to one tag, stall, release via commit1 only
        do_reset();
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
            exp(F_P0, 32 + i, "drain_p0");
        end
        idle(1'b1);
        exp(F_CNT, 1, "drain_cnt"); exp(F_RDY, 0, "drain_rdy"); exp(F_P0, 63, "drain_p0_last");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        exp(F_P0, 63, "stall_p0");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd5, 1'b0);
        exp(F_CNT, 1, "stall_ignored_cnt");
        idle(1'b1);
        exp(F_CNT, 2, "refill_cnt"); exp(F_RDY, 1, "refill_rdy");
        exp(F_P0, 63, "refill_p0"); exp(F_P1, 5, "refill_p1");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle(1'b0);
        exp(F_CNT, 0, "empty_cnt"); exp(F_RDY, 0, "empty_rdy");

        // Flush restores speculative allocations; same-cycle free still lands
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 6'd9, 1'b0);
        exp(F_CNT, 28, "pre_flush_cnt");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd11, 1'b0, 6'd0, 1'b1);
        exp(F_CNT, 30, "flush_cycle_cnt");
        idle(1'b0);
        exp(F_CNT, 32, "post_flush_cnt"); exp(F_P0, 35, "post_flush_p0"); exp(F_RDY, 1, "post_flush_rdy");
        for (int i = 0; i < 29; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
            exp(F_P0, 35 + i, "post_flush_walk");
        end
        idle(1'b1);
        exp(F_CNT, 3, "wrap_cnt"); exp(F_P0, 7, "wrap_p0"); exp(F_P1, 9, "wrap_p1");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle(1'b0);
        exp(F_P0, 11, "wrap_p0_last"); exp(F_CNT, 1, "wrap_cnt_last"); exp(F_OVF, 0, "wrap_ovf");

        // Overflow: full list, and one-short list with two frees
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0);
        exp(F_CNT, 32, "ovf_full_cnt_pre");
        idle(1'b1);
        exp(F_OVF, 1, "ovf_full_set"); exp(F_CNT, 32, "ovf_full_cnt");
        exp(F_P0, 32, "ovf_full_p0"); exp(F_P1, 33, "ovf_full_p1");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle(1'b0);
        exp(F_OVF, 1, "ovf_sticky"); exp(F_CNT, 31, "ovf_sticky_cnt");

        do_reset();
        idle(1'b0);
        exp(F_OVF, 0, "ovf_cleared");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0);
        idle(1'b1);
        exp(F_CNT, 32, "single_free_cnt"); exp(F_OVF, 0, "single_free_ovf"); exp(F_P0, 33, "single_free_p0");
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 6'd5, 1'b0);
        exp(F_CNT, 31, "double_free_pre_cnt");
        idle(1'b0);
        exp(F_CNT, 31, "double_free_cnt"); exp(F_OVF, 1, "double_free_ovf");

        // Random rename/commit/flush traffic
        do_reset();
        for (int i = 0; i < 64; i++) owned[i] = (i < 32);
        for (int i = 1; i < 32; i++) arch.push_back(i);
        for (int n = 0; n < 600; n++) begin
            mfree   = 32 - inflight.size();
            fire    = ($urandom_range(0, 3) != 0) && (mfree >= 2);
            r0      = 1'($urandom_range(0, 1));
            r1      = 1'($urandom_range(0, 1));
            fl      = ($urandom_range(0, 15) == 0);
            ncommit = $urandom_range(0, (inflight.size() < 2) ? inflight.size() : 2);
            freed.delete();
            for (int k = 0; k < ncommit; k++) begin
                t = inflight.pop_front();
                j = $urandom_range(0, arch.size() - 1);
                freed.push_back(arch[j]);
                arch.delete(j);
                arch.push_back(t);
            end
            c0v = 1'b0; c1v = 1'b0; c0p = '0; c1p = '0;
            if (ncommit == 2) begin
                c0v = 1'b1; c0p = 6'(freed[0]); c1v = 1'b1; c1p = 6'(freed[1]);
            end else if (ncommit == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    c0v = 1'b1; c0p = 6'(freed[0]);
                end else begin
                    c1v = 1'b1; c1p = 6'(freed[0]);
                end
            end
            drive(fire, r0, r1, c0v, c0p, c1v, c1p, fl);
            exp(F_RDY, int'(mfree >= 2), "rand_rdy");
            #2;
            if (fire && !fl) begin
                if (r0) begin
                    t = int'(instr0_alloc_preg);
                    check("rand_uniq0", int'(owned[t]), 0);
                    owned[t] = 1'b1;
                    inflight.push_back(t);
                end
                if (r1) begin
                    t = int'(instr1_alloc_preg);
                    check("rand_uniq1", int'(owned[t]), 0);
                    owned[t] = 1'b1;
                    inflight.push_back(t);
                end
            end
            foreach (freed[k]) owned[freed[k]] = 1'b0;
            if (fl) begin
                foreach (inflight[k]) owned[inflight[k]] = 1'b0;
                inflight.delete();
            end
            expect_at(cyc + 1, F_CNT, 32 - inflight.size(), "rand_cnt");
        end

        idle(1'b0);
        idle(1'b0);
        repeat (3) @(negedge clock);
        check("scoreboard_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
